// File: rtl/rv32i_types.sv
// Shared RV32I core types: register index widths and the retire/commit state.
package rv32i_types;

    localparam int ARCH_REG_BITS = 5;
    localparam int PHYS_REG_BITS = 6;
    localparam int NUM_ARCH_REGS = 32;

    // Retire FSM: RUN commits one head per cycle, FLUSH is the one-cycle redirect.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } commit_state_t;

endpackage

// File: rtl/rrat.sv
// Retirement register alias table: architectural -> committed physical mapping.
// One write port, one combinational read port, flat snapshot, identity reset.
// Entry 0 is hardwired to its reset mapping; writes to it are dropped.
module rrat
    import rv32i_types::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   we,
    input  logic [ARCH_REG_BITS-1:0]               waddr,
    input  logic [PHYS_REG_BITS-1:0]               wdata,
    input  logic [ARCH_REG_BITS-1:0]               raddr,
    output logic [PHYS_REG_BITS-1:0]               rdata,
    output logic [NUM_ARCH_REGS*PHYS_REG_BITS-1:0] snapshot
);

    logic [PHYS_REG_BITS-1:0] map_q [NUM_ARCH_REGS];

    // Identity mapping on reset, otherwise a single committed write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[i] <= PHYS_REG_BITS'(i);
            end
        end else if (we && (waddr != '0)) begin
            map_q[waddr] <= wdata;
        end
    end

    assign rdata = map_q[raddr];

    // Flatten the table so entry i sits at [i*PHYS_REG_BITS +: PHYS_REG_BITS].
    for (genvar g = 0; g < NUM_ARCH_REGS; g++) begin : g_snap
        assign snapshot[g*PHYS_REG_BITS +: PHYS_REG_BITS] = map_q[g];
    end

endmodule

// File: rtl/retire_commit.sv
// In-order retire stage: pops completed ROB heads, releases the previous
// physical mapping to the free list, updates the RRAT and raises a one-cycle
// flush after a mispredicted control transfer retires.
//
// Handshake: the ROB presents a head with rob_head_valid; the head is taken in
// the same cycle rob_dequeue is high (valid/ready style, no buffering here).
// The free list accepts free_list_enqueue only when free_list_full is low, so a
// register-writing head is held (not dequeued) while the free list is full.
module retire_commit
    import rv32i_types::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   rob_head_valid,
    input  logic [ARCH_REG_BITS-1:0]               rob_head_rd,
    input  logic [PHYS_REG_BITS-1:0]               rob_head_pd,
    input  logic                                   rob_head_we,
    input  logic                                   rob_head_mispredict,
    input  logic [31:0]                            rob_head_target,
    input  logic                                   free_list_full,
    output logic                                   rob_dequeue,
    output logic                                   free_list_enqueue,
    output logic [PHYS_REG_BITS-1:0]               free_list_preg,
    output logic                                   flush,
    output logic [31:0]                            flush_pc,
    output logic [NUM_ARCH_REGS*PHYS_REG_BITS-1:0] rrat_snapshot,
    output logic [63:0]                            commit_order,
    output commit_state_t                          state_dbg
);

    commit_state_t            state_q, state_d;
    logic                     eff_we;
    logic                     commit;
    logic [PHYS_REG_BITS-1:0] old_preg;
    logic [63:0]              order_q;
    logic [31:0]              flush_pc_q;

    // Writes to x0 are architecturally invisible and release nothing.
    assign eff_we = rob_head_we && (rob_head_rd != '0);

    // Next-state and commit decision; reset forces everything idle.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    commit = rob_head_valid && !(eff_we && free_list_full);
                    if (commit && rob_head_mispredict) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter and latched redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            order_q    <= 64'd0;
            flush_pc_q <= 32'd0;
        end else if (commit) begin
            order_q <= order_q + 64'd1;
            if (rob_head_mispredict) begin
                flush_pc_q <= rob_head_target;
            end
        end
    end

    rrat u_rrat (
        .clk      (clk),
        .rst      (rst),
        .we       (commit && eff_we),
        .waddr    (rob_head_rd),
        .wdata    (rob_head_pd),
        .raddr    (rob_head_rd),
        .rdata    (old_preg),
        .snapshot (rrat_snapshot)
    );

    assign rob_dequeue       = commit;
    assign free_list_enqueue = commit && eff_we;
    assign free_list_preg    = (commit && eff_we) ? old_preg : '0;
    assign flush             = (state_q == FLUSH);
    assign flush_pc          = flush_pc_q;
    assign commit_order      = order_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_retire_commit.sv
// Directed bench for retire_commit: a table of per-cycle vectors with
// hand-computed outputs, then a hand-written reset-during-flush sequence.
module tb_retire_commit;
    import rv32i_types::*;

    logic                                   clk;
    logic                                   rst;
    logic                                   rob_head_valid;
    logic [ARCH_REG_BITS-1:0]               rob_head_rd;
    logic [PHYS_REG_BITS-1:0]               rob_head_pd;
    logic                                   rob_head_we;
    logic                                   rob_head_mispredict;
    logic [31:0]                            rob_head_target;
    logic                                   free_list_full;
    logic                                   rob_dequeue;
    logic                                   free_list_enqueue;
    logic [PHYS_REG_BITS-1:0]               free_list_preg;
    logic                                   flush;
    logic [31:0]                            flush_pc;
    logic [NUM_ARCH_REGS*PHYS_REG_BITS-1:0] rrat_snapshot;
    logic [63:0]                            commit_order;
    commit_state_t                          state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    retire_commit dut (
        .clk                 (clk),
        .rst                 (rst),
        .rob_head_valid      (rob_head_valid),
        .rob_head_rd         (rob_head_rd),
        .rob_head_pd         (rob_head_pd),
        .rob_head_we         (rob_head_we),
        .rob_head_mispredict (rob_head_mispredict),
        .rob_head_target     (rob_head_target),
        .free_list_full      (free_list_full),
        .rob_dequeue         (rob_dequeue),
        .free_list_enqueue   (free_list_enqueue),
        .free_list_preg      (free_list_preg),
        .flush               (flush),
        .flush_pc            (flush_pc),
        .rrat_snapshot       (rrat_snapshot),
        .commit_order        (commit_order),
        .state_dbg           (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [5:0]  pd;
        logic        we;
        logic        mis;
        logic [31:0] target;
        logic        full;
        logic        e_deq;
        logic        e_enq;
        logic [5:0]  e_preg;
        logic        e_flush;
        logic [31:0] e_flush_pc;
        logic [63:0] e_order;
        int          chk_idx;
        logic [5:0]  chk_val;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [5:0] rrat_entry(int idx);
        return rrat_snapshot[idx*PHYS_REG_BITS +: PHYS_REG_BITS];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [5:0] pd,
                         input logic we, input logic mis, input logic [31:0] tgt,
                         input logic full);
        rob_head_valid      = v;
        rob_head_rd         = rd;
        rob_head_pd         = pd;
        rob_head_we         = we;
        rob_head_mispredict = mis;
        rob_head_target     = tgt;
        free_list_full      = full;
    endtask

    initial begin
        //          v   rd     pd     we  mis target         full deq enq preg   fl  flush_pc       order  idx val
        vecs[0]  = '{1, 5'd5, 6'd40, 1, 0, 32'h0,          0,   1,  1,  6'd5,  0,  32'h0,         64'd0, 5, 6'd5};
        vecs[1]  = '{1, 5'd5, 6'd41, 1, 0, 32'h0,          0,   1,  1,  6'd40, 0,  32'h0,         64'd1, 5, 6'd40};
        vecs[2]  = '{1, 5'd0, 6'd0,  1, 0, 32'h0,          1,   1,  0,  6'd0,  0,  32'h0,         64'd2, 5, 6'd41};
        vecs[3]  = '{1, 5'd7, 6'd20, 1, 0, 32'h0,          1,   0,  0,  6'd0,  0,  32'h0,         64'd3, 0, 6'd0};
        vecs[4]  = '{1, 5'd7, 6'd20, 1, 0, 32'h0,          1,   0,  0,  6'd0,  0,  32'h0,         64'd3, 7, 6'd7};
        vecs[5]  = '{1, 5'd7, 6'd20, 1, 0, 32'h0,          1,   0,  0,  6'd0,  0,  32'h0,         64'd3, 7, 6'd7};
        vecs[6]  = '{1, 5'd7, 6'd20, 1, 0, 32'h0,          0,   1,  1,  6'd7,  0,  32'h0,         64'd3, 7, 6'd7};
        vecs[7]  = '{0, 5'd3, 6'd9,  1, 1, 32'h1234,       0,   0,  0,  6'd0,  0,  32'h0,         64'd4, 7, 6'd20};
        vecs[8]  = '{1, 5'd2, 6'd33, 0, 0, 32'h0,          1,   1,  0,  6'd0,  0,  32'h0,         64'd4, 2, 6'd2};
        vecs[9]  = '{1, 5'd1, 6'd50, 1, 1, 32'h60000100,   0,   1,  1,  6'd1,  0,  32'h0,         64'd5, 1, 6'd1};
        vecs[10] = '{1, 5'd3, 6'd10, 1, 0, 32'h0,          0,   0,  0,  6'd0,  1,  32'h60000100,  64'd6, 1, 6'd50};
        vecs[11] = '{1, 5'd3, 6'd10, 1, 0, 32'h0,          0,   1,  1,  6'd3,  0,  32'h60000100,  64'd6, 3, 6'd3};
        vecs[12] = '{0, 5'd0, 6'd0,  0, 0, 32'h0,          0,   0,  0,  6'd0,  0,  32'h60000100,  64'd7, 3, 6'd10};

        // Reset with a live-looking head: combinational outputs must stay low.
        rst = 1'b1;
        drive(1, 5'd4, 6'd44, 1, 1, 32'hdead0000, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_dequeue", {63'd0, rob_dequeue}, 64'd0);
        check("rst_enqueue", {63'd0, free_list_enqueue}, 64'd0);
        check("rst_preg", {58'd0, free_list_preg}, 64'd0);
        check("rst_flush", {63'd0, flush}, 64'd0);
        check("rst_flush_pc", {32'd0, flush_pc}, 64'd0);
        check("rst_order", commit_order, 64'd0);
        check("rst_rrat31", {58'd0, rrat_entry(31)}, 64'd31);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven cycles: inputs set at negedge, sampled 1ns later.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].rd, vecs[i].pd, vecs[i].we,
                  vecs[i].mis, vecs[i].target, vecs[i].full);
            #1;
            check($sformatf("v%0d_dequeue", i), {63'd0, rob_dequeue}, {63'd0, vecs[i].e_deq});
            check($sformatf("v%0d_enqueue", i), {63'd0, free_list_enqueue}, {63'd0, vecs[i].e_enq});
            check($sformatf("v%0d_preg", i), {58'd0, free_list_preg}, {58'd0, vecs[i].e_preg});
            check($sformatf("v%0d_flush", i), {63'd0, flush}, {63'd0, vecs[i].e_flush});
            if (vecs[i].e_flush) begin
                check($sformatf("v%0d_flush_pc", i), {32'd0, flush_pc}, {32'd0, vecs[i].e_flush_pc});
            end
            check($sformatf("v%0d_order", i), commit_order, vecs[i].e_order);
            check($sformatf("v%0d_rrat%0d", i, vecs[i].chk_idx),
                  {58'd0, rrat_entry(vecs[i].chk_idx)}, {58'd0, vecs[i].chk_val});
            @(negedge clk);
        end
        check("rrat0_fixed", {58'd0, rrat_entry(0)}, 64'd0);

        // Reset arriving during the flush cycle cancels everything.
        drive(1, 5'd6, 6'd60, 1, 1, 32'h40000040, 0);
        #1;
        check("mis2_dequeue", {63'd0, rob_dequeue}, 64'd1);
        @(negedge clk);
        drive(0, 5'd0, 6'd0, 0, 0, 32'h0, 0);
        #1;
        check("mis2_flush", {63'd0, flush}, 64'd1);
        check("mis2_state", {63'd0, state_dbg}, {63'd0, FLUSH});
        check("mis2_flush_pc", {32'd0, flush_pc}, 64'h40000040);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_flush", {63'd0, flush}, 64'd0);
        check("post_rst_order", commit_order, 64'd0);
        check("post_rst_flush_pc", {32'd0, flush_pc}, 64'd0);
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            check($sformatf("post_rst_rrat%0d", i), {58'd0, rrat_entry(i)}, i);
        end
        @(negedge clk);
        #1;
        check("post_rst_no_pulse", {63'd0, flush}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/retire_commit.md
RETIRE_COMMIT -- requirements
Module: retire_commit

Interface
REQ-001 Constants SHALL come from rv32i_types: ARCH_REG_BITS, default 5, architectural register index width; PHYS_REG_BITS, default 6, physical register index width; NUM_ARCH_REGS, default 32, RRAT entries.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 rob_head_valid  in  1  ROB head entry present and completed.
REQ-005 rob_head_rd  in  ARCH_REG_BITS  head architectural destination.
REQ-006 rob_head_pd  in  PHYS_REG_BITS  head physical destination.
REQ-007 rob_head_we  in  1  head entry writes a register.
REQ-008 rob_head_mispredict  in  1  head is a mispredicted control transfer.
REQ-009 rob_head_target  in  32  correct PC for a mispredicted head.
REQ-010 free_list_full  in  1  free list cannot accept an enqueue this cycle.
REQ-011 rob_dequeue  out  1  pop ROB head this cycle.
REQ-012 free_list_enqueue  out  1  push free_list_preg into free list.
REQ-013 free_list_preg  out  PHYS_REG_BITS  physical register being released.
REQ-014 flush  out  1  one-cycle pipeline flush and RAT restore.
REQ-015 flush_pc  out  32  fetch redirect PC, valid while flush=1.
REQ-016 rrat_snapshot  out  NUM_ARCH_REGS*PHYS_REG_BITS  current RRAT, entry i at bits [i*PHYS_REG_BITS +: PHYS_REG_BITS].
REQ-017 commit_order  out  64  count of retired instructions.

Function
REQ-018 Block SHALL have two states: RUN and FLUSH.
REQ-019 Effective write: eff_we = rob_head_we && (rob_head_rd != 0).
REQ-020 Commit condition: state==RUN && rob_head_valid && !(eff_we && free_list_full).
REQ-021 rob_dequeue SHALL equal the commit condition combinationally, same cycle; at most one commit per cycle.
REQ-022 On commit with eff_we: free_list_enqueue=1 and free_list_preg = RRAT[rob_head_rd] before update, same cycle.
REQ-023 On commit with eff_we: RRAT[rob_head_rd] <= rob_head_pd at the next edge.
REQ-024 free_list_enqueue SHALL be 0 and free_list_preg 0 whenever no effective-write commit occurs.
REQ-025 RRAT[0] SHALL never change after reset.
REQ-026 Every commit SHALL increment commit_order by 1 at the next edge; 64-bit wrap to 0 permitted.
REQ-027 Commit with rob_head_mispredict: state <= FLUSH, flush_pc <= rob_head_target at the next edge.
REQ-028 In FLUSH: flush=1 for exactly one cycle, no commit, then state <= RUN.
REQ-029 flush SHALL be registered (asserted the cycle after the mispredict commit), 0 in RUN.
REQ-030 rrat_snapshot during flush SHALL include the mispredicting instruction's own RRAT update (e.g. JAL link register).
REQ-031 free_list_full with eff_we SHALL stall: no dequeue, no RRAT change, no order increment; head retried next cycle.
REQ-032 Non-writing head (store, branch, rd=0) SHALL commit regardless of free_list_full.
REQ-033 Inputs while rob_head_valid=0 SHALL be ignored.

Reset
REQ-034 On rst: RRAT[i] = i for all i, state = RUN, commit_order = 0, flush = 0, flush_pc = 0.
REQ-035 rst SHALL take priority over commit and FLUSH; rst mid-FLUSH aborts flush, no flush pulse after reset.
REQ-036 All combinational outputs SHALL be 0 during the reset cycle.

Structure
REQ-037 commit_state_t enum (RUN, FLUSH) SHALL be added to rv32i_types; existing width constants reused.
REQ-038 The RRAT SHALL be a sub-module rrat: one write port, one read port, flat snapshot output, identity reset.
REQ-039 The FSM, stall logic and order counter SHALL reside in retire_commit.

Verification
REQ-040 After reset, commit rd=5, pd=40, we=1 -> enqueue=1, preg=5, next cycle RRAT[5]=40, commit_order=1.
REQ-041 Then commit rd=5, pd=41 -> preg=40 released, RRAT[5]=41.
REQ-042 Commit rd=0, pd=0, we=1 with free_list_full=1 -> dequeue=1, enqueue=0, RRAT unchanged.
REQ-043 rd=7, we=1, free_list_full=1 for 3 cycles -> no dequeue 3 cycles; dequeue when full drops; order +1 only.
REQ-044 Mispredict JAL rd=1, pd=50, target 0x60000100 -> next cycle flush=1, flush_pc=0x60000100, snapshot entry 1 = 50; no dequeue that cycle.
REQ-045 rst asserted in FLUSH cycle -> flush=0 next cycle, RRAT identity, commit_order=0.
